reg_file: RTL and testbench
===========================

# reg_file

Architectural integer register file for the RISC-V core: NREG registers of XLEN bits with two combinational read ports (rs1/rs2) and one synchronous write port (rd). It is the read-side counterpart of the loadable register primitives. The ID stage reads operands from it, and the WB stage writes results into it. Register x0 is hardwired to zero. An internal write-to-read bypass removes the WB→ID hazard in the 5-stage pipeline.

## Interface
Parameters:
- XLEN, 32: register width in bits.
- NREG, 32: number of registers; must be a power of two.
- AW, 5: address width; must equal log2(NREG).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rs1  input  AW  read port 1 address.
- rs2  input  AW  read port 2 address.
- rd  input  AW  write address.
- reg_write  input  1  write enable.
- write_data  input  XLEN  data to write.
- read_data1  output  XLEN  contents of register rs1, after bypass.
- read_data2  output  XLEN  contents of register rs2, after bypass.

## Operation
- Storage is NREG×XLEN flops. Entry 0 is never written; it may be a constant instead of a flop.
- Write: at a rising clk edge with rst high, if reg_write=1 and rd≠0, then reg[rd] ← write_data. Otherwise all entries hold.
- A write with rd=0 is silently discarded, whether or not reg_write is set.
- Read port k (k=1,2) is combinational. It is evaluated in this priority order:
  1. If rst=0, read_data_k = 0.
  2. Else if rs_k = 0, read_data_k = 0.
  3. Else if reg_write=1 and rd = rs_k, read_data_k = write_data (bypass).
  4. Else read_data_k = reg[rs_k].
- The two read ports are independent. rs1 = rs2 is legal; both ports then return identical data, including the bypass case.
- No read-side state, no stalls and no handshake. The register file is always ready.
- Reset: asserting rst (low) clears every entry to 0 immediately, without waiting for clk. While rst is low, writes are ignored.

## Timing
- Read latency: 0 cycles. Outputs settle combinationally from rs1, rs2, rd, reg_write, write_data and rst.
- Write latency: 1 edge. Without the bypass, the new value would appear on a read in the cycle after the write edge. With the bypass, the new value is visible in the same cycle the write is presented.
- Reset values: read_data1 = read_data2 = 0; all entries = 0.
- Reset deasserted mid-cycle: the first write takes effect on the first rising edge with rst high.
- Reset asserted in the same cycle as a pending write: the write is lost and the entry reads 0.
- Simultaneous events:
  - Write to rd=r while both ports read r: both ports return write_data in that cycle, and reg[r] holds it from the next cycle.
  - Write to r while reading s≠r: the ports return the old reg[s]. Writes have no cross-port effect.
- Back-to-back writes to the same rd on consecutive edges: the last write wins, and each cycle's bypass shows that cycle's write_data.
- Address arithmetic is unsigned. No wrap-around is possible, because AW exactly covers NREG.

## Test plan
- Reset clear:
  - Write 0xDEADBEEF to x5, then pulse rst low between edges.
  - Required: read_data1 for x5 drops to 0 before the next edge, and all 31 registers read 0.
- x0 hardwired:
  - Apply reg_write=1, rd=0, write_data=0xFFFFFFFF for 3 cycles.
  - Required: rs1=0 and rs2=0 read 0 throughout, and the bypass never fires.
- Write/read all:
  - For r=1..31, write 0x1000_0000+r.
  - Then sweep rs1=r, rs2=32−r (mod 32).
  - Required: each port returns its own pattern; rs2=0 returns 0.
- Bypass:
  - Preload x7=0x11111111.
  - Same cycle: reg_write=1, rd=7, write_data=0x22222222, rs1=rs2=7.
  - Required: both ports return 0x22222222 in that cycle, and the next cycle (reg_write=0) also returns 0x22222222.
- Disabled write:
  - Apply reg_write=0, rd=9, write_data=0xABCD0000 with rs1=9, where x9=0x5.
  - Required: read_data1=0x5 both during and after the edge.
- Reset during write:
  - In the cycle with reg_write=1, rd=3, write_data=0x33, hold rst low across the edge.
  - Required: after rst returns high, x3 reads 0.

Source files
------------

// File: rtl/reg_file_if.sv
// Bus bundle for the architectural register file: two read ports and one write port.
// Handshake: none. The register file is always ready; reads are combinational
// and a write is accepted on every rising edge where reg_write=1.
interface reg_file_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic            reg_write;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;

  modport master (
    output rs1, rs2, rd, reg_write, write_data,
    input  read_data1, read_data2
  );

  modport slave (
    input  rs1, rs2, rd, reg_write, write_data,
    output read_data1, read_data2
  );
endinterface

// File: rtl/reg_file.sv
// RISC-V integer register file: NREG x XLEN, x0 hardwired to zero, two
// combinational read ports with same-cycle write-to-read bypass.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);

  logic [XLEN-1:0] mem [NREG];

  // Entry 0 is cleared on reset and never written, so it folds to a constant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.reg_write && (bus.rd != '0)) begin
      mem[bus.rd] <= bus.write_data;
    end
  end

  // Bypass lets ID see the value WB is writing in the same cycle.
  always_comb begin
    bus.read_data1 = '0;
    if (rst && (bus.rs1 != '0)) begin
      if (bus.reg_write && (bus.rd == bus.rs1)) begin
        bus.read_data1 = bus.write_data;
      end else begin
        bus.read_data1 = mem[bus.rs1];
      end
    end
  end

  always_comb begin
    bus.read_data2 = '0;
    if (rst && (bus.rs2 != '0)) begin
      if (bus.reg_write && (bus.rd == bus.rs2)) begin
        bus.read_data2 = bus.write_data;
      end else begin
        bus.read_data2 = mem[bus.rs2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_reg_file;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk;
  logic rst;
  reg_file_if #(.XLEN(XLEN), .AW(AW)) bus ();

  reg_file #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [XLEN-1:0] model [NREG];
  logic [XLEN-1:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] expected_read(input logic [AW-1:0] rs);
    if (!rst) return '0;
    if (rs == 0) return '0;
    if (bus.reg_write && bus.rd == rs) return bus.write_data;
    return model[rs];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) model[i] = '0;
  endtask

  // driver tasks
  task automatic drive(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [AW-1:0] wa, input logic we,
                       input logic [XLEN-1:0] wd);
    bus.rs1        = a1;
    bus.rs2        = a2;
    bus.rd         = wa;
    bus.reg_write  = we;
    bus.write_data = wd;
  endtask

  task automatic check_reads(input string tag);
    #1;
    exp_q.push_back(expected_read(bus.rs1));
    exp_q.push_back(expected_read(bus.rs2));
    check({tag, ".rd1"}, bus.read_data1, exp_q.pop_front());
    check({tag, ".rd2"}, bus.read_data2, exp_q.pop_front());
  endtask

  // Advance one clock: commit the write into the model if rst is high at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst && bus.reg_write && bus.rd != 0) model[bus.rd] = bus.write_data;
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
    drive(wa, wa, wa, 1'b1, wd);
    tick();
    drive(wa, wa, wa, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b0;
    model_clear();
    drive('0, '0, '0, 1'b0, '0);

    // reset state: every port reads zero while rst is low
    @(negedge clk);
    drive(5, 31, 5, 1'b1, 32'hFFFF_FFFF);
    check_reads("reset_hold");
    tick();
    drive(5, 31, 0, 1'b0, '0);
    rst = 1'b1;
    check_reads("after_reset");

    // reset clear mid-cycle
    write_reg(5, 32'hDEAD_BEEF);
    check(("x5_loaded"), bus.read_data1, 32'hDEAD_BEEF);
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    check("async_clear", bus.read_data1, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    for (int r = 1; r < NREG; r++) begin
      drive(r[AW-1:0], r[AW-1:0], 0, 1'b0, '0);
      check_reads($sformatf("cleared_x%0d", r));
    end

    // x0 hardwired
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 1'b1, 32'hFFFF_FFFF);
      check_reads("x0_write");
      check("x0_no_bypass", bus.read_data1, 32'h0);
      tick();
    end
    drive(0, 0, 0, 1'b0, '0);
    check_reads("x0_after");

    // write all, then cross sweep
    for (int r = 1; r < NREG; r++) write_reg(r[AW-1:0], 32'h1000_0000 + r);
    for (int r = 0; r < NREG; r++) begin
      drive(r[AW-1:0], (NREG - r) % NREG, 0, 1'b0, '0);
      check_reads($sformatf("sweep_%0d", r));
      check("sweep_pattern1", bus.read_data1, (r == 0) ? 32'h0 : 32'h1000_0000 + r);
    end

    // bypass
    write_reg(7, 32'h1111_1111);
    drive(7, 7, 7, 1'b1, 32'h2222_2222);
    check_reads("bypass");
    check("bypass_const", bus.read_data2, 32'h2222_2222);
    tick();
    drive(7, 7, 7, 1'b0, '0);
    check_reads("bypass_next");
    check("bypass_next_const", bus.read_data1, 32'h2222_2222);

    // disabled write
    write_reg(9, 32'h5);
    drive(9, 0, 9, 1'b0, 32'hABCD_0000);
    check_reads("disabled_during");
    check("disabled_const", bus.read_data1, 32'h5);
    tick();
    check_reads("disabled_after");
    check("disabled_after_const", bus.read_data1, 32'h5);

    // reset held across a pending write
    write_reg(3, 32'h77);
    drive(3, 3, 3, 1'b1, 32'h33);
    #2;
    rst = 1'b0;
    model_clear();
    tick();
    rst = 1'b1;
    drive(3, 3, 0, 1'b0, '0);
    check_reads("reset_write_lost");
    check("x3_zero", bus.read_data1, 32'h0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic [AW-1:0] a1, a2, wa;
      a1 = AW'($urandom_range(0, NREG - 1));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(0, NREG - 1));
      case ($urandom_range(0, 3))
        0:       wa = a1;
        1:       wa = a2;
        default: wa = AW'($urandom_range(0, NREG - 1));
      endcase
      drive(a1, a2, wa, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        model_clear();
        check_reads("rand_in_reset");
        rst = 1'b1;
      end
      check_reads($sformatf("rand_%0d", c));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
